spp_frame_collector13: RTL and testbench

- Upstream feeder for the 13x13 single-channel global max-pool stage in the SPP path.
- Accepts one DATA_WIDTH pixel per handshake in raster order (row-major, row 0 col 0 first).
- Assembles a complete InputH x InputW frame into one flat vector, in the exact layout the max-pool stage consumes.
- Presents that vector with a valid/ready handshake, holding it stable until the downstream stage accepts it.

---
 rtl/spp_frame_collector13.sv | 105 ++++++++++
 tb/tb_spp_frame_collector13.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spp_frame_collector13.sv
// Raster-order pixel collector for the 13x13 SPP max-pool stage.
// Builds a full InputH x InputW frame into one flat vector and hands it off with valid/ready.
module spp_frame_collector13 #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 13,
  parameter int InputW     = 13,
  localparam int NPIX      = InputH * InputW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [0:NPIX*DATA_WIDTH-1]   frame_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_error,
  output logic [15:0]                  frame_count
);

  localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPIX - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [0:NPIX*DATA_WIDTH-1]  frame_q;
  logic [15:0]                 count_q, count_d;
  logic                        err_q, err_d;
  logic                        wr_en;
  logic [31:0]                 wr_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // An early in_last drops the pixel instead of writing it; stale slots get overwritten by the next frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_base = 32'(idx_q) * 32'(DATA_WIDTH);
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            wr_en   = 1'b1;
            idx_d   = '0;
            err_d   = !in_last;
            state_d = HOLD;
          end else if (in_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          count_d = count_q + 16'd1;
          state_d = FILL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (wr_en) begin
        frame_q[wr_base +: DATA_WIDTH] <= in_data;
      end
    end
  end

  always_comb begin
    in_ready    = (state_q == FILL);
    out_valid   = (state_q == HOLD);
    frame_out   = frame_q;
    frame_error = err_q;
    frame_count = count_q;
  end

endmodule

// File: tb/tb_spp_frame_collector13.sv
// Bench for spp_frame_collector13: scenario table plus hand sequences, all checked every
// cycle against a queue-based frame model and a scoreboard of generated frames.
module tb_spp_frame_collector13;

  localparam int DW   = 16;
  localparam int H    = 13;
  localparam int W    = 13;
  localparam int NPIX = H * W;
  localparam int FW   = NPIX * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [0:FW-1]   frame_out;
  logic            out_valid;
  logic            out_ready;
  logic            frame_error;
  logic [15:0]     frame_count;

  always #5 clk = ~clk;

  spp_frame_collector13 #(
    .DATA_WIDTH(DW),
    .InputH(H),
    .InputW(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .frame_out(frame_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_error(frame_error),
    .frame_count(frame_count)
  );

  int compared = 0;
  int failed   = 0;
  int err_seen = 0;
  int hold_low = 0;
  bit rand_ready = 1'b0;
  bit last_acc;

  // Reference model: pixels collected so far, the frame on the output, handoff count
  bit            m_valid = 1'b0;
  bit            m_hold  = 1'b0;
  bit            m_err   = 1'b0;
  bit            m_fresh = 1'b0;
  logic [15:0]   m_cnt   = '0;
  logic [DW-1:0] m_part[$];
  logic [0:FW-1] m_held;
  logic [0:FW-1] sb[$];

  typedef struct {
    string       name;
    bit          pre_reset;
    int          nbeats;
    int          last_at;
    int          kind;      // 0 ramp, 1 fixed value, 2 random
    logic [15:0] fixed;
    int          hold;
    int          exp_err;
    logic [15:0] exp_cnt;
  } row_t;

  row_t rows[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input logic [0:FW-1] got, input logic [0:FW-1] exp);
    int bad = -1;
    for (int k = 0; k < NPIX; k++) begin
      if (bad < 0 && got[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    end
    compared++;
    if (bad >= 0) begin
      failed++;
      $display("FAIL %s: slice %0d got %h expected %h (t=%0t)", name, bad,
               got[bad*DW +: DW], exp[bad*DW +: DW], $time);
    end
  endtask

  task automatic tick();
    if (m_hold && hold_low > 0) begin
      out_ready = 1'b0;
      hold_low--;
    end else if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (frame_error === 1'b1) err_seen++;
    if (m_valid) begin
      chk("in_ready", 64'(in_ready), 64'(!m_hold));
      chk("out_valid", 64'(out_valid), 64'(m_hold));
      chk("frame_error", 64'(frame_error), 64'(m_err));
      chk("frame_count", 64'(frame_count), 64'(m_cnt));
      if (m_hold || m_fresh) chk_frame("frame_out", frame_out, m_held);
    end
    last_acc = 1'b0;
    m_err    = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_hold  = 1'b0;
      m_cnt   = '0;
      m_fresh = 1'b1;
      m_held  = '0;
      m_part.delete();
      sb.delete();
    end else if (m_valid) begin
      if (!m_hold) begin
        if (in_valid) begin
          last_acc = 1'b1;
          m_fresh  = 1'b0;
          if (m_part.size() == NPIX - 1) begin
            m_part.push_back(in_data);
            for (int k = 0; k < NPIX; k++) m_held[k*DW +: DW] = m_part[k];
            m_part.delete();
            m_hold = 1'b1;
            m_err  = !in_last;
          end else if (in_last) begin
            m_part.delete();
            m_err = 1'b1;
          end else begin
            m_part.push_back(in_data);
          end
        end
      end else if (out_ready) begin
        m_hold = 1'b0;
        m_cnt  = m_cnt + 16'd1;
        if (sb.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL handoff: frame delivered but scoreboard empty (t=%0t)", $time);
        end else begin
          chk_frame("handoff", frame_out, sb.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit gap);
    int n = 0;
    in_data = d;
    in_last = last;
    do begin
      in_valid = (gap && $urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
      tick();
      n++;
    end while (!last_acc && n < 2000);
    in_valid = 1'b0;
    if (!last_acc) begin
      compared++;
      failed++;
      $display("FAIL accept_timeout: beat not accepted after %0d cycles", n);
    end
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int kind,
                            input logic [15:0] fixed, input bit gap, input bit push);
    logic [0:FW-1] f = '0;
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = (kind == 0) ? DW'(b) : (kind == 1) ? fixed : DW'($urandom);
      if (b < NPIX) f[b*DW +: DW] = d;
      send_beat(d, b == last_at, gap);
    end
    if (push) sb.push_back(f);
  endtask

  task automatic drain();
    int n = 0;
    while (m_hold && n < 500) begin
      tick();
      n++;
    end
    if (m_hold) begin
      compared++;
      failed++;
      $display("FAIL drain_timeout: frame not handed off after %0d cycles", n);
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{"ramp",      1'b1, NPIX, NPIX - 1, 0, 16'h0000, 0,  0, 16'd1};
    rows[1] = '{"hold50",    1'b0, NPIX, NPIX - 1, 0, 16'h0000, 50, 0, 16'd2};
    rows[2] = '{"early99",   1'b1, 100,  99,       2, 16'h0000, 0,  1, 16'd0};
    rows[3] = '{"full7fff",  1'b0, NPIX, NPIX - 1, 1, 16'h7FFF, 0,  0, 16'd1};
    rows[4] = '{"nolast",    1'b0, NPIX, -1,       2, 16'h0000, 0,  1, 16'd2};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    do_reset();

    foreach (rows[i]) begin
      if (rows[i].pre_reset) do_reset();
      hold_low = rows[i].hold;
      err_seen = 0;
      send_frame(rows[i].nbeats, rows[i].last_at, rows[i].kind, rows[i].fixed,
                 1'b0, rows[i].nbeats == NPIX);
      drain();
      chk($sformatf("%s_err_pulses", rows[i].name), 64'(err_seen), 64'(rows[i].exp_err));
      chk($sformatf("%s_count", rows[i].name), 64'(frame_count), 64'(rows[i].exp_cnt));
    end

    // Ramp frame held on the output: explicit corner slices right after the last accept
    do_reset();
    hold_low = 3;
    send_frame(NPIX, NPIX - 1, 0, 16'h0000, 1'b0, 1'b1);
    chk("ramp_out_valid", 64'(out_valid), 64'd1);
    chk("ramp_slice0", 64'(frame_out[0:15]), 64'h0000);
    chk("ramp_slice168", 64'(frame_out[168*DW +: DW]), 64'h00A8);
    drain();
    chk("ramp_count", 64'(frame_count), 64'd1);

    // Reset in the middle of a frame, then a clean random frame
    send_frame(80, -1, 2, 16'h0000, 1'b0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = DW'($urandom);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("midreset_count", 64'(frame_count), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    send_frame(NPIX, NPIX - 1, 2, 16'h0000, 1'b0, 1'b1);
    drain();
    chk("midreset_final_count", 64'(frame_count), 64'd1);

    // Three frames with idle gaps and random backpressure
    do_reset();
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(NPIX, NPIX - 1, 2, 16'h0000, 1'b1, 1'b1);
    drain();
    rand_ready = 1'b0;
    chk("random_count", 64'(frame_count), 64'd3);
    chk("random_sb_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
